// File: rtl/dir_rom_scan_ctrl.sv
// Direction ROM scan sequencer: walks a 16x16 window through an external ROM
// and streams orientation-rotated bins to the descriptor histogram stage.
module dir_rom_scan_ctrl #(
  parameter int DIR_W  = 5,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIR_W-1:0]  ori_in,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DIR_W-1:0]  rom_spo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIR_W-1:0]  out_bin,
  output logic [ADDR_W/2-1:0] out_row,
  output logic [ADDR_W/2-1:0] out_col,
  output logic              out_last
);

  localparam int SIDE_W = ADDR_W / 2;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DIR_W-1:0] ori;
  logic             load;
  logic             addr_max;
  logic             last_hs;
  logic             start_acc;
  logic             abort_act;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort outranks every other event
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        if (abort)                state_nxt = IDLE;
        else if (load && addr_max) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort)        state_nxt = IDLE;
        else if (last_hs) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    addr_max  = (rom_addr == {ADDR_W{1'b1}});
    last_hs   = out_valid && out_ready && out_last;
    start_acc = (state == IDLE) && start;
    abort_act = abort && ((state == SCAN) || (state == DRAIN));
    load      = (state == SCAN) && !abort
                && (!out_valid || out_ready);
  end

  // Address counter, latched orientation and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr  <= '0;
      ori       <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else if (start_acc) begin
      ori      <= ori_in;
      rom_addr <= '0;
    end else if (abort_act) begin
      rom_addr  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_bin   <= rom_spo + ori;
      out_row   <= rom_addr[ADDR_W-1:SIDE_W];
      out_col   <= rom_addr[SIDE_W-1:0];
      out_last  <= addr_max;
      if (!addr_max) rom_addr <= rom_addr + ADDR_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dir_rom_scan_ctrl.sv
// Directed bench for dir_rom_scan_ctrl with a combinational ROM model
// and per-beat checking against hand-derived rotated bins.
module tb_dir_rom_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] ori_in;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] rom_addr;
  logic [4:0] rom_spo;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_bin;
  logic [3:0] out_row;
  logic [3:0] out_col;
  logic       out_last;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dir_rom_scan_ctrl #(.DIR_W(5), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .ori_in(ori_in),
    .abort(abort), .busy(busy), .done(done), .rom_addr(rom_addr),
    .rom_spo(rom_spo), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_row(out_row), .out_col(out_col),
    .out_last(out_last)
  );

  function automatic logic [4:0] rom_f(input logic [7:0] a);
    case (a)
      8'd0:    rom_f = 5'h17;
      8'd8:    rom_f = 5'h1F;
      8'd9:    rom_f = 5'h00;
      default: rom_f = a[4:0] ^ a[7:3];
    endcase
  endfunction

  always_comb rom_spo = rom_f(rom_addr);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one scan from the current negedge; cycle index 1 is the
  // negedge right after the edge that samples start.
  task automatic scan(input logic [4:0] o, input bit rnd,
                      input bit poke, output int nb, output int nd,
                      output int tf, output int td,
                      output logic [4:0] b0, output logic [4:0] b8,
                      output logic [4:0] b9);
    logic [14:0] held;
    logic [13:0] exp;
    logic [7:0]  a;
    logic [4:0]  eb;
    bit          stall;
    nb = 0; nd = 0; tf = -1; td = -1;
    b0 = '0; b8 = '0; b9 = '0;
    stall = 1'b0; held = '0;
    ori_in = o; start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ori_in = o ^ 5'h15;
    for (int i = 1; i < 3000; i++) begin
      @(negedge clk);
      if (stall)
        check("stable",
              {out_valid, out_bin, out_row, out_col, out_last}, held);
      if (out_valid && tf < 0) tf = i;
      if (done) begin
        nd++;
        if (td < 0) td = i;
      end
      start = poke && (i == 60 || done);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = out_valid && !out_ready;
      held = {out_valid, out_bin, out_row, out_col, out_last};
      if (out_valid && out_ready) begin
        a = nb[7:0];
        eb = rom_f(a) + o;
        exp = {eb, a[7:4], a[3:0], (nb == 255)};
        check("beat", {out_bin, out_row, out_col, out_last}, exp);
        if (nb == 0) b0 = out_bin;
        if (nb == 8) b8 = out_bin;
        if (nb == 9) b9 = out_bin;
        nb++;
      end
      if (td >= 0 && i >= td + 3) break;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("idle_after", {busy, out_valid}, 2'b00);
  endtask

  int nb, nd, tf, td, cnt;
  logic [4:0] b0, b8, b9;

  initial begin
    rst = 1'b1; start = 1'b0; ori_in = '0;
    abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, out_valid}, 3'b000);
    check("rst_addr", rom_addr, 8'h00);
    check("rst_out", {out_bin, out_row, out_col, out_last}, 14'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // T1 full-rate scan, latency and first bin 0x17+0x0A
    scan(5'h0A, 1'b0, 1'b0, nb, nd, tf, td, b0, b8, b9);
    check("t1_first", tf, 2);
    check("t1_bin0", b0, 5'h01);
    check("t1_done_t", td, 258);
    check("t1_beats", nb, 256);
    check("t1_dones", nd, 1);

    // T2 wrap of bin arithmetic
    scan(5'h1F, 1'b0, 1'b0, nb, nd, tf, td, b0, b8, b9);
    check("t2_bin8", b8, 5'h1E);
    check("t2_bin9", b9, 5'h1F);
    check("t2_beats", nb, 256);

    // T3 random backpressure
    scan(5'h05, 1'b1, 1'b0, nb, nd, tf, td, b0, b8, b9);
    check("t3_beats", nb, 256);
    check("t3_dones", nd, 1);
    check("t3_first", tf, 2);

    // T5 start in SCAN and DONE ignored
    scan(5'h11, 1'b0, 1'b1, nb, nd, tf, td, b0, b8, b9);
    check("t5_beats", nb, 256);
    check("t5_dones", nd, 1);
    check("t5_done_t", td, 258);

    // T4 abort while beat 100 is stalled
    ori_in = 5'h03; start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid && cnt == 100) break;
      if (out_valid && out_ready) cnt++;
    end
    check("t4_pre", {out_valid, out_row, out_col}, {1'b1, 8'd100});
    out_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_valid", out_valid, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_addr", rom_addr, 8'h00);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("t4_nodone", nd, 0);
    out_ready = 1'b1;
    scan(5'h03, 1'b0, 1'b0, nb, nd, tf, td, b0, b8, b9);
    check("t4_rescan", nb, 256);
    check("t4_refirst", tf, 2);

    // T6 asynchronous reset mid-scan
    ori_in = 5'h07; start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #1 check("t6_pre", {busy, out_valid}, 2'b11);
    #1 rst = 1'b1;
    #1 check("t6_async",
             {busy, done, out_valid, rom_addr, out_bin,
              out_row, out_col, out_last}, 25'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_idle", {busy, done, out_valid}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
